pma_check_pipe: RTL

- Two-stage pipelined Physical Memory Attribute (PMA) checker.
- Sits directly downstream of the core configuration. It consumes the compile-time PMA rule tables in `cva6_cfg_t` (non-idempotent, execute and cached regions) and classifies physical addresses presented by the MMU/PTW or fetch path.
- Returns per-request attributes plus an instruction-fetch fault flag over a valid/ready interface.
- Throughput is one request per cycle.

---
 rtl/config_pkg.sv | 42 ++++
 rtl/pma_pipe_reg.sv | 33 +++
 rtl/pma_check_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Core configuration slice: PMA rule tables, the shared attribute format and range helpers.
package config_pkg;

    localparam int unsigned NrMaxRules = 16;
    localparam int unsigned AddrWidth  = 64;

    typedef struct packed {
        int unsigned                                NrNonIdempotentRules;
        logic [NrMaxRules-1:0][AddrWidth-1:0]       NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][AddrWidth-1:0]       NonIdempotentLength;
        int unsigned                                NrExecuteRegionRules;
        logic [NrMaxRules-1:0][AddrWidth-1:0]       ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][AddrWidth-1:0]       ExecuteRegionLength;
        int unsigned                                NrCachedRegionRules;
        logic [NrMaxRules-1:0][AddrWidth-1:0]       CachedRegionAddrBase;
        logic [NrMaxRules-1:0][AddrWidth-1:0]       CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    // Attribute bundle shared by MMU and LSU.
    typedef struct packed {
        logic nonidem;
        logic exec;
        logic cached;
    } pma_attr_t;

    // End computed in 65 bits so regions reaching 2^64 do not wrap; len 0 never matches.
    function automatic logic range_check(input logic [AddrWidth-1:0] base,
                                         input logic [AddrWidth-1:0] len,
                                         input logic [AddrWidth-1:0] address);
        return (address >= base) &&
               ({1'b0, address} < (65'(base) + 65'(len)));
    endfunction

    function automatic bit check_cfg(input cva6_cfg_t cfg);
        return (cfg.NrNonIdempotentRules <= NrMaxRules) &&
               (cfg.NrExecuteRegionRules <= NrMaxRules) &&
               (cfg.NrCachedRegionRules  <= NrMaxRules);
    endfunction

endpackage

// File: rtl/pma_pipe_reg.sv
// Valid/ready register slice with synchronous flush; payload is an opaque vector.
module pma_pipe_reg #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready_c,
    input  logic [Width-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [Width-1:0] dn_data
);

    assign up_ready_c = !dn_valid || dn_ready;

    // Flush wins over load; data only moves when a new item is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (flush) begin
            dn_valid <= 1'b0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pma_check_pipe.sv
// Two-stage PMA checker: S1 registers per-rule matches, S2 reduces them to attributes.
module pma_check_pipe
    import config_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           IdWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [63:0]          req_addr_i,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic                 req_fetch_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [63:0]          rsp_addr_o,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 rsp_nonidem_o,
    output logic                 rsp_exec_o,
    output logic                 rsp_cached_o,
    output logic                 rsp_fault_o
);

    if (!check_cfg(CVA6Cfg)) begin : g_cfg_error
        $error("pma_check_pipe: PMA rule count exceeds NrMaxRules");
    end

    typedef struct packed {
        logic [AddrWidth-1:0]  addr;
        logic [IdWidth-1:0]    id;
        logic                  fetch;
        logic [NrMaxRules-1:0] match_nonidem;
        logic [NrMaxRules-1:0] match_exec;
        logic [NrMaxRules-1:0] match_cached;
    } s1_payload_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [IdWidth-1:0]   id;
        pma_attr_t            attr;
        logic                 fault;
    } s2_payload_t;

    localparam int unsigned S1Width = $bits(s1_payload_t);
    localparam int unsigned S2Width = $bits(s2_payload_t);

    s1_payload_t s1_in;
    s1_payload_t s1_q;
    s2_payload_t s2_in;
    s2_payload_t s2_q;
    logic        s1_valid;
    logic        s2_valid;
    logic        adv1;
    logic        adv2;

    // Per-rule match vectors; slots beyond the configured count stay 0.
    always_comb begin
        s1_in       = '0;
        s1_in.addr  = req_addr_i;
        s1_in.id    = req_id_i;
        s1_in.fetch = req_fetch_i;
        for (int unsigned k = 0; k < NrMaxRules; k++) begin
            s1_in.match_nonidem[k] = (k < CVA6Cfg.NrNonIdempotentRules) &&
                range_check(CVA6Cfg.NonIdempotentAddrBase[k], CVA6Cfg.NonIdempotentLength[k], req_addr_i);
            s1_in.match_exec[k] = (k < CVA6Cfg.NrExecuteRegionRules) &&
                range_check(CVA6Cfg.ExecuteRegionAddrBase[k], CVA6Cfg.ExecuteRegionLength[k], req_addr_i);
            s1_in.match_cached[k] = (k < CVA6Cfg.NrCachedRegionRules) &&
                range_check(CVA6Cfg.CachedRegionAddrBase[k], CVA6Cfg.CachedRegionLength[k], req_addr_i);
        end
    end

    // With no execute rules configured, everything is executable.
    always_comb begin
        s2_in             = '0;
        s2_in.addr        = s1_q.addr;
        s2_in.id          = s1_q.id;
        s2_in.attr.nonidem = |s1_q.match_nonidem;
        s2_in.attr.exec    = (CVA6Cfg.NrExecuteRegionRules == 0) ? 1'b1 : |s1_q.match_exec;
        s2_in.attr.cached  = |s1_q.match_cached;
        s2_in.fault        = s1_q.fetch && !s2_in.attr.exec;
    end

    pma_pipe_reg #(
        .Width (S1Width)
    ) i_s1 (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .flush      (flush_i),
        .up_valid   (req_valid_i && !flush_i),
        .up_ready_c (adv1),
        .up_data    (s1_in),
        .dn_valid   (s1_valid),
        .dn_ready   (adv2),
        .dn_data    (s1_q)
    );

    pma_pipe_reg #(
        .Width (S2Width)
    ) i_s2 (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .flush      (flush_i),
        .up_valid   (s1_valid),
        .up_ready_c (adv2),
        .up_data    (s2_in),
        .dn_valid   (s2_valid),
        .dn_ready   (rsp_ready_i),
        .dn_data    (s2_q)
    );

    assign req_ready_o   = adv1 && !flush_i;
    assign rsp_valid_o   = s2_valid;
    assign rsp_addr_o    = s2_q.addr;
    assign rsp_id_o      = s2_q.id;
    assign rsp_nonidem_o = s2_q.attr.nonidem;
    assign rsp_exec_o    = s2_q.attr.exec;
    assign rsp_cached_o  = s2_q.attr.cached;
    assign rsp_fault_o   = s2_q.fault;

endmodule
